// File: rtl/pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_select_adder
//
// Purpose:
//   Pipelined, block-segmented carry-select adder. Operands are split into
//   BLOCK_BIT-wide blocks. Stage 0 registers both candidate sums/carries of
//   every block (carry-in 0 and carry-in 1). Stages 1..S each resolve
//   SEL_PER_STAGE blocks with the running carry. Latency is 1+S cycles and
//   throughput is one beat per cycle when not stalled.
//
// Parameters:
//   N_BIT          operand/sum width (multiple of BLOCK_BIT)
//   BLOCK_BIT      carry-select block width (N_BLK = N_BIT/BLOCK_BIT)
//   SEL_PER_STAGE  blocks resolved per select stage (S = N_BLK/SEL_PER_STAGE)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   operand_1  in   addend A
//   operand_2  in   addend B
//   carry_in   in   carry into bit 0
//   subtract   in   (CSA_SUB_EN only) B -> ~B, effective cin = carry_in ^ subtract
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   sum        out  A+B+cin mod 2^N_BIT
//   carry_out  out  carry out of bit N_BIT-1
//   overflow   out  signed overflow (carry into MSB XOR carry_out)
//
// Configuration macro:
//   CSA_SUB_EN  adds the subtract port; undefined builds an add-only unit.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
//   high. The whole pipeline moves as one (advance = ~out_valid | out_ready);
//   when it does not advance every stage register and valid bit holds, so a
//   presented result stays stable until taken. in_ready equals advance.
// -----------------------------------------------------------------------------
module pipelined_carry_select_adder #(
  parameter int N_BIT         = 32,
  parameter int BLOCK_BIT     = 8,
  parameter int SEL_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] operand_1,
  input  logic [N_BIT-1:0] operand_2,
  input  logic             carry_in,
`ifdef CSA_SUB_EN
  input  logic             subtract,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N_BLK = N_BIT / BLOCK_BIT;
  localparam int S     = N_BLK / SEL_PER_STAGE;

  // Per-stage registers, index 0 = input stage, index S = output stage.
  // sum0 holds the carry-in-0 candidate; once a block is resolved its final
  // value is written into the sum0 field and carried forward from there.
  logic [S:0][N_BIT-1:0] sum0_q, sum0_d;
  logic [S:0][N_BIT-1:0] sum1_q, sum1_d;
  logic [S:0][N_BLK-1:0] cout0_q, cout0_d;
  logic [S:0][N_BLK-1:0] cout1_q, cout1_d;
  logic [S:0]            carry_q, carry_d;   // running carry into next unresolved block
  logic [S:0]            cm0_q, cm0_d;       // carry into MSB, top block cin=0
  logic [S:0]            cm1_q, cm1_d;       // carry into MSB, top block cin=1
  logic [S:0]            ovf_q, ovf_d;       // valid once the top block is resolved
  logic [S:0]            valid_q, valid_d;

  logic                  advance;
  logic [N_BIT-1:0]      b_eff;
  logic                  cin_eff;
  logic [BLOCK_BIT:0]    t0, t1;
  logic                  c;
  int                    blk;

`ifdef CSA_SUB_EN
  assign b_eff   = subtract ? ~operand_2 : operand_2;
  assign cin_eff = carry_in ^ subtract;
`else
  assign b_eff   = operand_2;
  assign cin_eff = carry_in;
`endif

  assign advance   = ~valid_q[S] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[S];
  assign sum       = sum0_q[S];
  assign carry_out = carry_q[S];
  assign overflow  = ovf_q[S];

  always_comb begin
    sum0_d  = '0;
    sum1_d  = '0;
    cout0_d = '0;
    cout1_d = '0;
    carry_d = '0;
    cm0_d   = '0;
    cm1_d   = '0;
    ovf_d   = '0;
    valid_d = '0;
    t0      = '0;
    t1      = '0;
    c       = 1'b0;
    blk     = 0;

    // Stage 0: both candidates of every block.
    for (int k = 0; k < N_BLK; k++) begin
      t0 = {1'b0, operand_1[k*BLOCK_BIT +: BLOCK_BIT]}
         + {1'b0, b_eff[k*BLOCK_BIT +: BLOCK_BIT]};
      t1 = t0 + {{BLOCK_BIT{1'b0}}, 1'b1};
      sum0_d[0][k*BLOCK_BIT +: BLOCK_BIT] = t0[BLOCK_BIT-1:0];
      sum1_d[0][k*BLOCK_BIT +: BLOCK_BIT] = t1[BLOCK_BIT-1:0];
      cout0_d[0][k] = t0[BLOCK_BIT];
      cout1_d[0][k] = t1[BLOCK_BIT];
    end
    // Carry into the MSB recovered from the MSB sum bit: a ^ b ^ s.
    cm0_d[0]   = operand_1[N_BIT-1] ^ b_eff[N_BIT-1] ^ sum0_d[0][N_BIT-1];
    cm1_d[0]   = operand_1[N_BIT-1] ^ b_eff[N_BIT-1] ^ sum1_d[0][N_BIT-1];
    carry_d[0] = cin_eff;
    valid_d[0] = in_valid;

    // Stages 1..S: resolve a group of blocks, pass the rest through.
    for (int j = 1; j <= S; j++) begin
      sum0_d[j]  = sum0_q[j-1];
      sum1_d[j]  = sum1_q[j-1];
      cout0_d[j] = cout0_q[j-1];
      cout1_d[j] = cout1_q[j-1];
      cm0_d[j]   = cm0_q[j-1];
      cm1_d[j]   = cm1_q[j-1];
      ovf_d[j]   = ovf_q[j-1];
      valid_d[j] = valid_q[j-1];
      c          = carry_q[j-1];
      for (int i = 0; i < SEL_PER_STAGE; i++) begin
        blk = (j - 1) * SEL_PER_STAGE + i;
        if (c) begin
          sum0_d[j][blk*BLOCK_BIT +: BLOCK_BIT] = sum1_q[j-1][blk*BLOCK_BIT +: BLOCK_BIT];
        end
        if (blk == N_BLK - 1) begin
          ovf_d[j] = (c ? cm1_q[j-1] : cm0_q[j-1])
                   ^ (c ? cout1_q[j-1][blk] : cout0_q[j-1][blk]);
        end
        c = c ? cout1_q[j-1][blk] : cout0_q[j-1][blk];
      end
      carry_d[j] = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum0_q  <= '0;
      sum1_q  <= '0;
      cout0_q <= '0;
      cout1_q <= '0;
      carry_q <= '0;
      cm0_q   <= '0;
      cm1_q   <= '0;
      ovf_q   <= '0;
      valid_q <= '0;
    end else if (advance) begin
      sum0_q  <= sum0_d;
      sum1_q  <= sum1_d;
      cout0_q <= cout0_d;
      cout1_q <= cout1_d;
      carry_q <= carry_d;
      cm0_q   <= cm0_d;
      cm1_q   <= cm1_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Candidate fields of the output stage are fully consumed by then.
  logic unused_tail;
  assign unused_tail = ^{sum1_q[S], cout0_q[S], cout1_q[S], cm0_q[S], cm1_q[S]};

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder (N_BIT=32, BLOCK_BIT=8, SEL_PER_STAGE=2).
module tb_pipelined_carry_select_adder;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] operand_1 = '0;
  logic [W-1:0] operand_2 = '0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
`ifdef CSA_SUB_EN
  logic         subtract = 1'b0;
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  pipelined_carry_select_adder #(
    .N_BIT(W), .BLOCK_BIT(8), .SEL_PER_STAGE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .operand_1(operand_1),
    .operand_2(operand_2),
    .carry_in(carry_in),
`ifdef CSA_SUB_EN
    .subtract(subtract),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .carry_out(carry_out),
    .overflow(overflow)
  );

  // ---------------- scoreboard state ----------------
  // Entry format: {overflow, carry_out, sum}
  logic [W+1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           rand_rdy = 1'b0;
  bit           hold_v = 1'b0;
  logic [W+1:0] hold_val = '0;

  // Reference: plain wide arithmetic and the signed-overflow rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   w;
    logic         ovf;
    be  = sub ? ~b : b;
    w   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cin ^ sub};
    ovf = (a[W-1] == be[W-1]) && (w[W-1] != a[W-1]);
    return {ovf, w[W], w[W-1:0]};
  endfunction

  task automatic check_vec(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      check_bit("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold_v) begin
        check_bit("stall_valid_held", out_valid, 1'b1);
        check_vec("stall_data_held", {overflow, carry_out, sum}, hold_val);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h required=none at %0t",
                   {overflow, carry_out, sum}, $time);
        end else begin
          check_vec("result", {overflow, carry_out, sum}, exp_q.pop_front());
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {overflow, carry_out, sum};
    end
  end

  // Random backpressure while enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input bit use_lit, input logic [W+1:0] lit);
    operand_1 = a;
    operand_2 = b;
    carry_in  = cin;
`ifdef CSA_SUB_EN
    subtract  = sub;
`endif
    in_valid  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(use_lit ? lit : model(a, b, cin, sub));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout actual=not_accepted required=accepted at %0t", $time);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_vec("reset_outputs", {overflow, carry_out, sum}, '0);
    check_bit("reset_in_ready", in_ready, 1'b1);

    // Single beat with latency probe.
    out_ready = 1'b1;
    send_beat(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b00, 32'h0000_0100});
    @(posedge clk);
    #1;
    check_bit("latency_not_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_bit("latency_on_time", out_valid, 1'b1);
    drain();

    // Hand-computed corner beats, back to back.
    send_beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, {2'b01, 32'h0000_0000});
    send_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b10, 32'h8000_0000});
    send_beat(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, {2'b11, 32'h0000_0000});
    send_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b01, 32'h0000_0000});
    send_beat(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b1, {2'b00, 32'h2143_6588});
    if (SUB_EN) begin
      send_beat(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, {2'b00, 32'hFFFF_FFFE});
      send_beat(32'd5, 32'd7, 1'b1, 1'b1, 1'b1, {2'b00, 32'hFFFF_FFFD});
      send_beat(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, {2'b11, 32'h7FFF_FFFF});
    end
    drain();

    // Fill with out_ready low, hold, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
    a = $urandom;
    b = $urandom;
    operand_1 = a;
    operand_2 = b;
    carry_in  = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("full_in_ready_low", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(a, b, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("release_one_per_cycle", out_valid, 1'b1);
    end
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat($urandom, $urandom, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_bit("midreset_out_valid", out_valid, 1'b0);
    check_vec("midreset_outputs", {overflow, carry_out, sum}, '0);
    check_bit("midreset_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send_beat(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 1'b1, {2'b00, 32'h0000_0008});
    drain();

    // Random traffic with random backpressure and bubbles.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(pick(), pick(), 1'($urandom_range(0, 1)),
                SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, '0);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
